// File: rtl/univ_shift_seq_register_if.sv
// univ_shift_seq_register_if: request/status bus of the sequenced universal shift register
interface univ_shift_seq_register_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
);
   logic             start;
   logic [2:0]       op;
   logic [CNT_W-1:0] amt;
   logic [WIDTH-1:0] d;
   logic             si;
   logic [WIDTH-1:0] q;
   logic             shout;
   logic             busy;
   logic             done;
   modport master (output start, op, amt, d, si, input q, shout, busy, done);
   modport slave  (input start, op, amt, d, si, output q, shout, busy, done);
endinterface

// File: rtl/univ_shift_seq_register.sv
// univ_shift_seq_register: universal shift/rotate register that executes
// multi-bit shifts one bit per clock under a start/busy/done handshake.
module univ_shift_seq_register #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input logic                     clk,
   input logic                     rst_n,
   univ_shift_seq_register_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef enum logic [2:0] {OP_HOLD, OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR, OP_LOAD, OP_CLR} op_t;
   localparam logic [CNT_W-1:0] W_C   = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
   state_t           state_q, state_d;
   op_t              op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             si_q, si_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             shout_q, shout_d;
   logic [WIDTH-1:0] step_q;
   logic             step_sh;
   logic             is_shift;
   assign is_shift = (bus.op != 3'd0) && (bus.op < 3'd6);
   always_comb begin
      step_q  = q_q;
      step_sh = shout_q;
      case (op_q)
         OP_SHL:  begin step_q = {q_q[WIDTH-2:0], si_q};         step_sh = q_q[WIDTH-1]; end
         OP_SHR:  begin step_q = {si_q, q_q[WIDTH-1:1]};         step_sh = q_q[0];       end
         OP_ROL:  begin step_q = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; step_sh = q_q[WIDTH-1]; end
         OP_ROR:  begin step_q = {q_q[0], q_q[WIDTH-1:1]};       step_sh = q_q[0];       end
         OP_ASR:  begin step_q = {q_q[WIDTH-1], q_q[WIDTH-1:1]}; step_sh = q_q[0];       end
         OP_LOAD: step_q = data_q;
         OP_CLR:  step_q = '0;
         default: ;
      endcase
   end
   // A shift by zero is captured as HOLD so it runs one step without touching shout.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      si_d    = si_q;
      q_d     = q_q;
      shout_d = shout_q;
      case (state_q)
         IDLE: if (bus.start) begin
            op_d    = (is_shift && bus.amt == '0) ? OP_HOLD : op_t'(bus.op);
            cnt_d   = !is_shift ? ONE_C : bus.amt > W_C ? W_C : bus.amt == '0 ? ONE_C : bus.amt;
            data_d  = bus.d;
            si_d    = bus.si;
            state_d = RUN;
         end
         RUN: begin
            q_d     = step_q;
            shout_d = step_sh;
            cnt_d   = cnt_q - ONE_C;
            state_d = cnt_q == ONE_C ? DONE : RUN;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= OP_HOLD;
         cnt_q   <= '0;
         data_q  <= '0;
         si_q    <= 1'b0;
         q_q     <= '0;
         shout_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         si_q    <= si_d;
         q_q     <= q_d;
         shout_q <= shout_d;
      end
   end
   assign bus.q     = q_q;
   assign bus.shout = shout_q;
   assign bus.busy  = state_q == RUN;
   assign bus.done  = state_q == DONE;
endmodule

// File: tb/tb_univ_shift_seq_register.sv
// tb_univ_shift_seq_register: directed scoreboard bench for the sequenced shift register (WIDTH=8).
module tb_univ_shift_seq_register;
   typedef struct {logic [7:0] q; logic sh; int n;} exp_t;
   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad = 0;
   int   nb;
   int   ndone;
   int   first_c;
   logic [7:0] trace [16];
   exp_t sb [$];
   univ_shift_seq_register_if #(.WIDTH(8), .CNT_W(4)) bus ();
   univ_shift_seq_register #(.WIDTH(8), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // Caller is at a negedge; the op is accepted at the next posedge.
   task automatic do_op(input string tag, input logic [2:0] o, input logic [3:0] a, input logic [7:0] dd,
                        input logic s, input logic [7:0] eq, input logic esh, input int en, input bit disturb);
      exp_t e;
      bit got = 0;
      sb.push_back('{eq, esh, en});
      bus.start = 1'b1; bus.op = o; bus.amt = a; bus.d = dd; bus.si = s;
      nb = 0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk);
         if (c == 0) bus.start = 1'b0;
         if (disturb && c == 1) begin bus.start = 1'b1; bus.op = 3'b111; bus.amt = 4'd1; bus.d = 8'hFF; bus.si = 1'b1; end
         if (disturb && c == 2) bus.start = 1'b0;
         if (bus.done) got = 1;
         else if (bus.busy && nb < 16) begin trace[nb] = bus.q; nb++; end
      end
      chk({tag, " done_seen"}, got, 1);
      e = sb.pop_front();
      if (got) begin
         chk({tag, " q"}, bus.q, e.q);
         chk({tag, " shout"}, bus.shout, e.sh);
         chk({tag, " busy_cycles"}, nb, e.n);
         @(negedge clk);
         chk({tag, " done_one_cycle"}, bus.done, 0);
      end
   endtask
   initial begin
      rst_n = 1'b0;
      bus.start = 1'b0; bus.op = 3'd0; bus.amt = 4'd0; bus.d = 8'h00; bus.si = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset q", bus.q, 8'h00);
      chk("reset shout", bus.shout, 0);
      chk("reset busy", bus.busy, 0);
      chk("reset done", bus.done, 0);
      rst_n = 1'b1;
      @(negedge clk);
      do_op("load11", 3'b110, 4'd0, 8'h11, 1'b0, 8'h11, 1'b0, 1, 0);
      // Abort a ROL amt=5 two cycles in with an asynchronous reset.
      bus.start = 1'b1; bus.op = 3'b011; bus.amt = 4'd5;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      chk("abort busy_before", bus.busy, 1);
      rst_n = 1'b0;
      #1;
      chk("abort q", bus.q, 8'h00);
      chk("abort busy", bus.busy, 0);
      chk("abort shout", bus.shout, 0);
      ndone = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c == 3) rst_n = 1'b1;
         if (bus.done) ndone++;
      end
      chk("abort no_done", ndone, 0);
      do_op("loadA5", 3'b110, 4'd0, 8'hA5, 1'b0, 8'hA5, 1'b0, 1, 0);
      do_op("rol3", 3'b011, 4'd3, 8'h00, 1'b0, 8'h2D, 1'b1, 3, 0);
      chk("rol3 step0", trace[0], 8'hA5);
      chk("rol3 step1", trace[1], 8'h4B);
      chk("rol3 step2", trace[2], 8'h96);
      do_op("ror8", 3'b100, 4'd8, 8'h00, 1'b0, 8'h2D, 1'b0, 8, 0);
      do_op("load81", 3'b110, 4'd0, 8'h81, 1'b0, 8'h81, 1'b0, 1, 0);
      do_op("shl2", 3'b001, 4'd2, 8'h00, 1'b1, 8'h07, 1'b0, 2, 0);
      do_op("shr8", 3'b010, 4'd8, 8'h00, 1'b0, 8'h00, 1'b0, 8, 0);
      do_op("load90", 3'b110, 4'd0, 8'h90, 1'b1, 8'h90, 1'b0, 1, 0);
      do_op("asr3_disturbed", 3'b101, 4'd3, 8'h00, 1'b0, 8'hF2, 1'b0, 3, 1);
      do_op("asr15", 3'b101, 4'd15, 8'h00, 1'b0, 8'hFF, 1'b1, 8, 0);
      do_op("shl0", 3'b001, 4'd0, 8'h00, 1'b0, 8'hFF, 1'b1, 1, 0);
      // start held high: LOAD 0x3C, then SHR 1 accepted after done + IDLE.
      sb.push_back('{8'h3C, 1'b1, 1});
      sb.push_back('{8'h1E, 1'b0, 1});
      bus.start = 1'b1; bus.op = 3'b110; bus.amt = 4'd0; bus.d = 8'h3C; bus.si = 1'b0;
      ndone = 0;
      first_c = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c == 0) begin bus.op = 3'b010; bus.amt = 4'd1; bus.d = 8'h00; end
         if (bus.done) begin
            exp_t e;
            e = sb.pop_front();
            ndone++;
            chk("b2b q", bus.q, e.q);
            chk("b2b shout", bus.shout, e.sh);
            if (ndone == 1) first_c = c;
            else begin
               chk("b2b spacing", c - first_c, 3);
               bus.start = 1'b0;
            end
         end
      end
      chk("b2b done_count", ndone, 2);
      chk("scoreboard empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/univ_shift_seq_register.md
Name: univ_shift_seq_register

Overview:
- Parametrised successor to the team's 4-mode universal shift register.
- Adds configurable width, rotate and arithmetic modes, and multi-bit shifts by a runtime amount.
- Multi-bit shifts run as a sequenced operation, one bit per clock, under a start/busy/done handshake.
- Sits in datapaths needing serialisers, barrel-shift substitutes, or bit-level framing without a combinational barrel shifter.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- CNT_W, $clog2(WIDTH)+1, width of the shift-amount input and internal down-counter; must represent WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  operation code, captured on accept.
- amt  input  CNT_W  shift count, captured on accept.
- d  input  WIDTH  parallel load data, captured on accept.
- si  input  1  serial fill bit for SHL/SHR, captured on accept.
- q  output  WIDTH  register contents.
- shout  output  1  last bit shifted out by the most recent shift op.
- busy  output  1  high while an op is executing.
- done  output  1  one-cycle pulse when an op completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - q=0, shout=0, busy=0, done=0.
  - State -> IDLE, counter=0.
  - Mid-operation reset aborts the op immediately; no done pulse is produced.
- Op codes:
  - 000 HOLD
  - 001 SHL: q <= {q[WIDTH-2:0], si}; shout=q[WIDTH-1]
  - 010 SHR (logical): q <= {si, q[WIDTH-1:1]}; shout=q[0]
  - 011 ROL
  - 100 ROR
  - 101 ASR: fill with q[WIDTH-1]; shout=q[0]
  - 110 LOAD: q <= d
  - 111 CLEAR: q <= 0
- States:
  - IDLE: busy=0. On start=1, capture op, amt, d, si, then go to RUN.
  - RUN: busy=1. One step per clock; counter decrements each cycle. On the step where counter=1, go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle, then go to IDLE. start is ignored in DONE, so back-to-back accepts are at best 1 op per N+2 cycles.
- Step count N, loaded into the counter on accept:
  - Shift/rotate ops: N = max(amt,1) when amt<=WIDTH; amt>WIDTH saturates to WIDTH.
  - amt=0 on a shift op behaves as HOLD: one RUN cycle, q unchanged, shout unchanged.
  - HOLD, LOAD, CLEAR: N=1.
- Latency:
  - Accept at edge 0; q updates at edges 1..N.
  - done is high in the cycle after edge N; ready for a new start in the cycle after done.
- shout:
  - Updated on every shift step, so it holds the bit expelled on the final step.
  - Unchanged by HOLD, LOAD, CLEAR.
- Boundaries:
  - Rotate by WIDTH returns the original q.
  - SHL/SHR by WIDTH fills q entirely with si.
  - ASR by WIDTH gives all bits equal to the original MSB.
- Input stability:
  - op, amt, d, si changes during RUN/DONE have no effect; the captured values are used.
  - start held high continuously re-accepts in each IDLE cycle.
- q is purely registered; no combinational path from inputs to any output.

Test Plan (WIDTH=8):
- Reset: drive reset=0 mid-RUN of ROL amt=5 -> q=0x00, busy=0, done never pulses; release, start LOAD d=0xA5 -> q=0xA5 after edge 1, done pulses the next cycle.
- Rotate: q=0xA5, ROL amt=3 -> busy high 3 cycles, q steps 0x4B, 0x96, 0x2D; done one cycle; shout=1. Then ROR amt=8 -> q=0x2D unchanged.
- Shift fill: q=0x81, SHL amt=2 si=1 -> q=0x07, shout=0. SHR amt=8 si=0 -> q=0x00.
- Arithmetic: q=0x90, ASR amt=3 -> q=0xF2, shout=0. amt=15 saturates to 8 steps -> q=0xFF.
- Handshake: pulse start while busy with op=CLEAR -> ignored, q unaffected. SHL amt=0 -> one busy cycle, q and shout unchanged, done pulses.
- Back-to-back: start held high with LOAD 0x3C, then SHR amt=1 -> accepts separated by done+IDLE; q=0x3C, then 0x1E; exactly two done pulses.
